multi_ch_freq_counter: RTL
==========================

// Module: multi_ch_freq_counter
// PURPOSE
//  NCH-channel gated edge counter: the parametrised successor of the single-channel edge counter.
//  Per channel: synchronises fin, detects edges (rise/fall/both), counts over a programmable gate of clk cycles.
//  At gate end, latches counts into cnt_mem, pulses done; supports one-shot or continuous gating, abort and saturation.
//  Sits between the external test inputs and the register/readout logic of the frequency-counter design.
// PARAMETERS
//  NCH      4    number of fin channels (>=1)
//  CW       16   per-channel count width
//  GW       16   gate-length width, in clk cycles
//  FILT_LEN 3    glitch-filter stability length, in cycles (used only with FCNT_GLITCH_FILTER_EN; >=2)
// PORTS
//  clk         in   1       system clock, rising edge
//  sync_rst    in   1       synchronous reset, active-high
//  fin         in   NCH     asynchronous measured inputs
//  edge_mode   in   2       00/11=rise, 01=fall, 10=both; sampled on start
//  gate_len    in   GW      gate length in clk cycles; sampled on start and each continuous re-arm
//  start       in   1       level-sampled; starts a measurement from IDLE
//  stop        in   1       aborts the gate
//  continuous  in   1       1: re-arm after each latch
//  busy        out  1       1 in GATE/LATCH
//  done        out  1       1-cycle pulse; cnt_mem/ovf_mem updated in the same cycle
//  pos_edge    out  NCH     per-channel edge-detect strobe (selected mode), debug
//  cnt_out     out  NCH*CW  live counters; channel i at [i*CW +: CW]
//  cnt_mem     out  NCH*CW  latched result of the last completed gate
//  ovf_mem     out  NCH     latched saturation flags of the last completed gate
// BEHAVIOUR
//  Reset (sync_rst=1 at a clk edge): all outputs 0, synchroniser flops 0, state IDLE. Reset overrides any state.
//  Sync: s1<=fin, s2<=s1, s3<=s2.
//  Edge strobes: rise=s2&~s3; fall=~s2&s3; pos_edge = strobe for the mode selected by edge_mode.
//   pos_edge is high for exactly 1 cycle, 2 clk edges after fin is first sampled changed.
//  Input limits: fin high and low times must each be >=1 clk period. Shorter pulses may be missed; this is unspecified.
//  FSM IDLE -> GATE -> LATCH -> (GATE | IDLE):
//   IDLE:
//    - start=1 & stop=0 & gate_len!=0: load gcnt=gate_len-1, clear cnt_out and the internal ovf, latch edge_mode; go to GATE.
//    - start with gate_len==0: ignored.
//    - start while busy: ignored.
//   GATE (exactly gate_len cycles):
//    - Each cycle, each channel with pos_edge=1: cnt_out+=1.
//    - At all-ones the counter holds and that channel's ovf is set (sticky to the gate).
//    - gcnt decrements each cycle; in the cycle with gcnt==0, go to LATCH.
//    - stop=1: go to IDLE next cycle, cnt_mem/ovf_mem unchanged, no done.
//   LATCH (1 cycle):
//    - Edges in this cycle are not counted; this is the dead cycle in continuous mode.
//    - At the end of this cycle: cnt_mem<=cnt_out, ovf_mem<=ovf, done<=1 for 1 cycle.
//    - Next state: continuous=1 & stop=0 & gate_len!=0 re-arms (clear counters, reload gcnt) to GATE; otherwise IDLE.
//    - stop in LATCH still completes the latch and done, then goes to IDLE.
//  Simultaneous events:
//    - start&stop in IDLE: stop wins.
//    - An edge strobe at saturation: counter holds, ovf set.
//  Timing: busy=1 from the cycle after the accepted start until the cycle after LATCH.
//   Measurement cycle = gate_len+1 clk; done appears gate_len+1 cycles after the first GATE cycle.
// CONFIGURATION
//  FCNT_GLITCH_FILTER_EN defined:
//   - The per-channel filtered level replaces s2 in the edge logic.
//   - The filtered level changes only after s2 holds the new value for FILT_LEN consecutive cycles.
//   - Adds FILT_LEN cycles of latency; pulses shorter than FILT_LEN cycles are rejected.
//  Not defined: edge logic uses s2 directly; FILT_LEN is unused; no filter flops are synthesised.
// TESTING (clk 20ns, NCH=4, CW=16 unless stated)
//  1. fin[0] period 100ns, gate_len=100, rise mode, one-shot -> single done; cnt_mem[0]=20, ovf_mem[0]=0; busy=0 afterwards.
//  2. Same stimulus, edge_mode=10 -> cnt_mem[0]=40. fin[1] held low -> cnt_mem[1]=0.
//  3. CW=8, fin[2] toggling every clk (period 40ns), gate_len=1000 -> cnt_mem[2]=255, ovf_mem[2]=1.
//  4. continuous=1, gate_len=50, fin period 100ns -> done every 51 cycles, each cnt_mem[0] in {10,11}.
//     Deassert continuous -> exactly one more done, then IDLE.
//  5. stop at cycle 30 of a 100-cycle gate -> no done, cnt_mem keeps prior value.
//     sync_rst mid-GATE -> all outputs 0 on the next cycle.
//  6. FCNT_GLITCH_FILTER_EN, FILT_LEN=3: 2-cycle fin pulses -> count 0; 5-cycle pulses x10 -> count 10.
//     Without the macro, the same 2-cycle pulses x10 -> count 10.

Source files
------------

// File: rtl/multi_ch_freq_counter.sv
// NCH-channel gated edge counter: synchronised inputs, selectable edge mode, one-shot or continuous gating.
// Define FCNT_GLITCH_FILTER_EN to insert a FILT_LEN-cycle stability filter after each input synchroniser.
module multi_ch_freq_counter #(
  parameter int NCH      = 4,
  parameter int CW       = 16,
  parameter int GW       = 16,
  parameter int FILT_LEN = 3
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic [NCH-1:0]    fin,
  input  logic [1:0]        edge_mode,
  input  logic [GW-1:0]     gate_len,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  output logic              busy,
  output logic              done,
  output logic [NCH-1:0]    pos_edge,
  output logic [NCH*CW-1:0] cnt_out,
  output logic [NCH*CW-1:0] cnt_mem,
  output logic [NCH-1:0]    ovf_mem
);

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NCH-1:0]    lvl, lvl_prev, rise, fall;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [NCH*CW-1:0] cnt_q, cnt_d, mem_q, mem_d;
  logic [NCH-1:0]    ovf_q, ovf_d, ovf_mem_q, ovf_mem_d;
  logic              done_q, done_d;

  always_comb begin
    s1_d = fin;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

`ifdef FCNT_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN);

  logic [NCH-1:0]         filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [NCH-1:0][FW-1:0] stab_q, stab_d;

  // The filtered level follows s2 only once s2 has disagreed with it for FILT_LEN cycles in a row.
  always_comb begin
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    stab_d      = stab_q;
    for (int i = 0; i < NCH; i++) begin
      if (s2_q[i] == filt_q[i]) begin
        stab_d[i] = '0;
      end else if (stab_q[i] == FW'(FILT_LEN - 1)) begin
        filt_d[i] = s2_q[i];
        stab_d[i] = '0;
      end else begin
        stab_d[i] = stab_q[i] + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      filt_q      <= '0;
      filt_prev_q <= '0;
      stab_q      <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      stab_q      <= stab_d;
    end
  end

  assign lvl      = filt_q;
  assign lvl_prev = filt_prev_q;
`else
  assign lvl      = s2_q;
  assign lvl_prev = s3_q;
`endif

  assign rise = lvl & ~lvl_prev;
  assign fall = ~lvl & lvl_prev;

  always_comb begin
    case (mode_q)
      2'b01:   pos_edge = fall;
      2'b10:   pos_edge = rise | fall;
      default: pos_edge = rise;
    endcase
  end

  // Gate sequencing: counters run only in GATE; LATCH is the dead cycle that publishes results.
  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;
    ovf_mem_d = ovf_mem_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (gate_len != '0)) begin
          state_d = GATE;
          gcnt_d  = gate_len - GW'(1);
          cnt_d   = '0;
          ovf_d   = '0;
          mode_d  = edge_mode;
        end
      end
      GATE: begin
        for (int i = 0; i < NCH; i++) begin
          if (pos_edge[i]) begin
            if (&cnt_q[i*CW +: CW]) begin
              ovf_d[i] = 1'b1;
            end else begin
              cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + CW'(1);
            end
          end
        end
        if (stop) begin
          state_d = IDLE;
        end else if (gcnt_q == '0) begin
          state_d = LATCH;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      LATCH: begin
        mem_d     = cnt_q;
        ovf_mem_d = ovf_q;
        done_d    = 1'b1;
        if (continuous && !stop && (gate_len != '0)) begin
          state_d = GATE;
          gcnt_d  = gate_len - GW'(1);
          cnt_d   = '0;
          ovf_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= IDLE;
      gcnt_q    <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
      mem_q     <= '0;
      ovf_mem_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
      ovf_mem_q <= ovf_mem_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign cnt_out = cnt_q;
  assign cnt_mem = mem_q;
  assign ovf_mem = ovf_mem_q;

endmodule
